// File: rtl/sync_fifo_p.sv
// ============================================================================
// Module   : sync_fifo_p
// Brief    : Single-clock FIFO with registered read data, occupancy count,
//            almost-full/almost-empty thresholds and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = (2 ** ADDR_W) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              r_en,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wfull,
  output logic              rempty,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] c_AF    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] c_AE    = (ADDR_W + 1)'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_overflow;
  logic              r_underflow;

  logic w_wr_acc;
  logic w_rd_acc;

  // Status flags depend only on the registered count, never on this cycle's requests.
  assign wfull        = (r_count == c_DEPTH);
  assign rempty       = (r_count == '0);
  assign almost_full  = (r_count >= c_AF);
  assign almost_empty = (r_count <= c_AE);

  assign w_wr_acc = w_en & ~wfull  & ~clr;
  assign w_rd_acc = r_en & ~rempty & ~clr;

  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rdata <= r_mem[r_rptr[ADDR_W-1:0]];
        r_rptr  <= r_rptr + 1'b1;
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_en && wfull) begin
        r_overflow <= 1'b1;
      end
      if (r_en && rempty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_p.sv
// ============================================================================
// Module   : tb_sync_fifo_p
// Brief    : Scoreboard bench for sync_fifo_p (DEPTH=4) with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_p;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int AF     = 3;
  localparam int AE     = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              w_en = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic              r_en = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wfull;
  logic              rempty;
  logic [ADDR_W:0]   count;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  sync_fifo_p #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the FIFO is just a queue plus two sticky bits.
  logic [DATA_W-1:0] m_q [$];
  logic [DATA_W-1:0] sb_q [$];
  logic [DATA_W-1:0] m_rdata = '0;
  bit                m_rvalid = 0;
  bit                m_ovf = 0;
  bit                m_unf = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    chk("count",        int'(count),        m_q.size());
    chk("wfull",        int'(wfull),        int'(m_q.size() == DEPTH));
    chk("rempty",       int'(rempty),       int'(m_q.size() == 0));
    chk("almost_full",  int'(almost_full),  int'(m_q.size() >= AF));
    chk("almost_empty", int'(almost_empty), int'(m_q.size() <= AE));
    chk("overflow",     int'(overflow),     int'(m_ovf));
    chk("underflow",    int'(underflow),    int'(m_unf));
    chk("rdata_hold",   int'(rdata),        int'(m_rdata));
    chk("rvalid",       int'(rvalid),       int'(m_rvalid));
  endtask

  task automatic model_reset();
    m_q.delete();
    sb_q.delete();
    m_rdata  = '0;
    m_rvalid = 0;
    m_ovf    = 0;
    m_unf    = 0;
  endtask

  // One clock of stimulus; model advances on the same edge, checks land 1 time unit later.
  task automatic cycle(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit c);
    bit wacc, racc;
    w_en = w; wdata = d; r_en = r; clr = c;
    @(posedge clk);
    wacc = w && (m_q.size() < DEPTH) && !c;
    racc = r && (m_q.size() > 0) && !c;
    if (c) begin
      m_q.delete();
      m_ovf = 0; m_unf = 0; m_rvalid = 0;
    end else begin
      if (w && m_q.size() == DEPTH) m_ovf = 1;
      if (r && m_q.size() == 0)     m_unf = 1;
      if (racc) begin
        m_rdata = m_q.pop_front();
        sb_q.push_back(m_rdata);
      end
      if (wacc) m_q.push_back(d);
      m_rvalid = racc;
    end
    #1;
    w_en = 0; r_en = 0; clr = 0;
    check_status();
  endtask

  // Monitor: every rvalid beat must match the oldest outstanding scoreboard entry.
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rvalid", 1, 0);
      end else begin
        chk("sb_rdata", int'(rdata), int'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state, held across edges.
    repeat (2) @(posedge clk);
    #1;
    check_status();
    @(negedge clk);
    rst = 0;
    #1;

    // Fill then overflow.
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0);
    chk("af_at_3", int'(almost_full), 1);
    cycle(1, 8'h44, 0, 0);
    chk("full_at_4", int'(wfull), 1);
    cycle(1, 8'h55, 0, 0);
    chk("ovf_5th_write", int'(overflow), 1);
    chk("count_stays_4", int'(count), 4);

    // Drain then underflow (clear the sticky overflow first).
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h11 * (i + 1)), 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    chk("unf_5th_read", int'(underflow), 1);
    chk("rdata_stays_44", int'(rdata), 8'h44);
    chk("rvalid_low_on_unf", int'(rvalid), 0);

    // Wrap with interleaved pairs.
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 8'(8'hA0 + i), 0, 0);
      cycle(0, 8'h00, 1, 0);
    end

    // Simultaneous on full, then on empty.
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'hB0 + i), 0, 0);
    cycle(1, 8'hBF, 1, 0);
    chk("simul_full_count", int'(count), 3);
    chk("simul_full_ovf", int'(overflow), 1);
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'hC7, 1, 0);
    chk("simul_empty_count", int'(count), 1);
    chk("simul_empty_unf", int'(underflow), 1);
    chk("simul_empty_rvalid", int'(rvalid), 0);

    // Flush with a concurrent write at count 3.
    cycle(1, 8'hC8, 0, 0);
    cycle(1, 8'hC9, 0, 0);
    cycle(1, 8'hCA, 0, 1);
    chk("clr_count", int'(count), 0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset between edges; outputs must react before any clock.
    cycle(1, 8'hD0, 0, 0);
    cycle(1, 8'hD1, 0, 0);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    model_reset();
    check_status();
    @(negedge clk);
    rst = 0;
    #1;
    cycle(1, 8'hE1, 0, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
